mmio_responder: RTL

- Memory-mapped I/O and CSR responder in stage 3 of the 3-stage RISC-V pipeline.
- Consumes the stage-2 memory request (ALU-result address, store data, mem_wen, load strobe) and the CSR write strobe.
- Services the UART, cycle/instruction counters and the tohost CSR.
- Returns registered load data to the writeback mux one cycle after the request.

---
 rtl/mmio_responder.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/mmio_responder.sv
// mmio_responder: stage-3 MMIO/CSR responder (UART, counters, tohost).
// Optional branch counters at 0x1C/0x20 are built when MMIO_BRANCH_CNT_EN is defined.
module mmio_responder #(
  parameter logic [3:0]  MMIO_BASE  = 4'h8,
  parameter logic [11:0] CSR_TOHOST = 12'h51E
) (
  input  logic        clk,
  input  logic        rst,
`ifdef MMIO_BRANCH_CNT_EN
  input  logic        br_valid,
  input  logic        br_correct,
`endif
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        mem_wen,
  input  logic        mem_ren,
  input  logic        stall,
  input  logic        inst_retire,
  input  logic        csr_we,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  output logic [31:0] rdata,
  output logic [31:0] tohost,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_valid,
  input  logic        uart_tx_ready,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_valid,
  output logic        uart_rx_ready
);

  // Word offsets (addr[7:2]) of the register map.
  localparam logic [5:0] OFF_STATUS = 6'h00;
  localparam logic [5:0] OFF_RXDATA = 6'h01;
  localparam logic [5:0] OFF_TXDATA = 6'h02;
  localparam logic [5:0] OFF_CYCLE  = 6'h04;
  localparam logic [5:0] OFF_INST   = 6'h05;
  localparam logic [5:0] OFF_CLEAR  = 6'h06;
`ifdef MMIO_BRANCH_CNT_EN
  localparam logic [5:0] OFF_BR     = 6'h07;
  localparam logic [5:0] OFF_BR_OK  = 6'h08;
`endif

  logic [5:0]  offset;
  logic        hit;
  logic        rd_hit;
  logic        wr_hit;
  logic        cnt_clear;
  logic        tx_push;
  logic        tx_valid_q;
  logic [31:0] rd_val;
  logic [31:0] cycle_cnt;
  logic [31:0] inst_cnt;
  logic        unused_addr_bits;

`ifdef MMIO_BRANCH_CNT_EN
  logic [31:0] br_cnt;
  logic [31:0] br_ok_cnt;
`endif

  // Only the top nibble and the word offset take part in decode.
  assign unused_addr_bits = ^{addr[27:8], addr[1:0]};

  assign offset    = addr[7:2];
  assign hit       = (addr[31:28] == MMIO_BASE) && !stall;
  assign rd_hit    = hit && mem_ren;
  assign wr_hit    = hit && mem_wen;
  assign cnt_clear = wr_hit && (offset == OFF_CLEAR);

  // A byte is accepted only when nothing is pending and the UART is ready.
  assign tx_push = wr_hit && (offset == OFF_TXDATA)
                && uart_tx_ready && !tx_valid_q;

  // Reset drops a pending byte in the same cycle, not one edge later.
  assign uart_tx_valid = tx_valid_q && !rst;

  // The pop happens in the request cycle, alongside latching the byte.
  assign uart_rx_ready = rd_hit && (offset == OFF_RXDATA)
                      && uart_rx_valid;

  // Read map, sampled from pre-update register values.
  always_comb begin
    rd_val = 32'h0;
    case (offset)
      OFF_STATUS: rd_val = {30'b0, uart_rx_valid, uart_tx_ready};
      OFF_RXDATA: rd_val = {24'b0, uart_rx_data};
      OFF_CYCLE:  rd_val = cycle_cnt;
      OFF_INST:   rd_val = inst_cnt;
`ifdef MMIO_BRANCH_CNT_EN
      OFF_BR:     rd_val = br_cnt;
      OFF_BR_OK:  rd_val = br_ok_cnt;
`endif
      default:    rd_val = 32'h0;
    endcase
  end

  // Load data register: one-cycle latency, holds when no load hit.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= 32'h0;
    end else if (rd_hit) begin
      rdata <= rd_val;
    end
  end

  // UART transmit holding register and valid handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_valid_q   <= 1'b0;
      uart_tx_data <= 8'h0;
    end else if (tx_push) begin
      tx_valid_q   <= 1'b1;
      uart_tx_data <= wdata[7:0];
    end else if (tx_valid_q && uart_tx_ready) begin
      tx_valid_q   <= 1'b0;
    end
  end

  // Cycle/instruction counters; a clear wins over the increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt <= 32'h0;
      inst_cnt  <= 32'h0;
    end else if (cnt_clear) begin
      cycle_cnt <= 32'h0;
      inst_cnt  <= 32'h0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      inst_cnt  <= inst_cnt + {31'b0, inst_retire};
    end
  end

`ifdef MMIO_BRANCH_CNT_EN
  // Branch statistics counters, cleared together with the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      br_cnt    <= 32'h0;
      br_ok_cnt <= 32'h0;
    end else if (cnt_clear) begin
      br_cnt    <= 32'h0;
      br_ok_cnt <= 32'h0;
    end else begin
      br_cnt    <= br_cnt + {31'b0, br_valid};
      br_ok_cnt <= br_ok_cnt + {31'b0, br_valid && br_correct};
    end
  end
`endif

  // tohost CSR capture; stalled instructions have no side effects.
  always_ff @(posedge clk) begin
    if (rst) begin
      tohost <= 32'h0;
    end else if (csr_we && !stall && (csr_addr == CSR_TOHOST)) begin
      tohost <= csr_wdata;
    end
  end

endmodule
